// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID/EX pipeline register and the EX-stage ALU.
// The shamt signal exists only when ALU_EXEC_SHIFT_EN is defined.
interface alu_exec_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  src_a;
  logic [DATA_W-1:0]  src_b;
  logic [DATA_W-1:0]  result;
  logic               result_valid;
  logic               zero;
`ifdef ALU_EXEC_SHIFT_EN
  logic [4:0]         shamt;

  modport slave (input in_valid, alu_op, funct, src_a, src_b, shamt,
                 output in_ready, result, result_valid, zero);
  modport master (output in_valid, alu_op, funct, src_a, src_b, shamt,
                  input in_ready, result, result_valid, zero);
`else
  modport slave (input in_valid, alu_op, funct, src_a, src_b,
                 output in_ready, result, result_valid, zero);
  modport master (output in_valid, alu_op, funct, src_a, src_b,
                  input in_ready, result, result_valid, zero);
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_op/funct, single-cycle logic/arith, iterative mult/div with HI/LO.
// Optional shifter enabled by defining ALU_EXEC_SHIFT_EN.
module alu_exec_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CNT_W   = 6
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave ex_io
);
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'(6'b101011);
  localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
`ifdef ALU_EXEC_SHIFT_EN
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] F_SLLV  = FUNCT_W'(6'b000100);
  localparam logic [FUNCT_W-1:0] F_SRLV  = FUNCT_W'(6'b000110);
  localparam logic [FUNCT_W-1:0] F_SRAV  = FUNCT_W'(6'b000111);
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
  typedef enum logic [4:0] {
    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_NOR,
    OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_SLL, OP_SRL, OP_SRA
  } op_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic                rv_q, rv_d, zero_q, zero_d, ready_q, ready_d;
  logic                is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  op_e                 op;
  logic [DATA_W-1:0]   sc_res;
`ifdef ALU_EXEC_SHIFT_EN
  logic                var_sh;
  logic [4:0]          sh_amt;
`endif

  // Instruction decode
  always_comb begin
    op = OP_AND;
`ifdef ALU_EXEC_SHIFT_EN
    var_sh = 1'b0;
`endif
    unique case (ex_io.alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default: begin
        case (ex_io.funct)
          F_AND:   op = OP_AND;
          F_OR:    op = OP_OR;
          F_ADD:   op = OP_ADD;
          F_SUB:   op = OP_SUB;
          F_SLT:   op = OP_SLT;
          F_SLTU:  op = OP_SLTU;
          F_XOR:   op = OP_XOR;
          F_NOR:   op = OP_NOR;
          F_MFHI:  op = OP_MFHI;
          F_MFLO:  op = OP_MFLO;
          F_MULT:  op = OP_MULT;
          F_MULTU: op = OP_MULTU;
          F_DIV:   op = OP_DIV;
          F_DIVU:  op = OP_DIVU;
`ifdef ALU_EXEC_SHIFT_EN
          F_SLL:   op = OP_SLL;
          F_SRL:   op = OP_SRL;
          F_SRA:   op = OP_SRA;
          F_SLLV:  begin op = OP_SLL; var_sh = 1'b1; end
          F_SRLV:  begin op = OP_SRL; var_sh = 1'b1; end
          F_SRAV:  begin op = OP_SRA; var_sh = 1'b1; end
`endif
          default: op = OP_AND;
        endcase
      end
    endcase
  end

  // Single-cycle result
  always_comb begin
    sc_res = ex_io.src_a & ex_io.src_b;
`ifdef ALU_EXEC_SHIFT_EN
    sh_amt = var_sh ? ex_io.src_a[4:0] : ex_io.shamt;
`endif
    case (op)
      OP_OR:   sc_res = ex_io.src_a | ex_io.src_b;
      OP_ADD:  sc_res = ex_io.src_a + ex_io.src_b;
      OP_SUB:  sc_res = ex_io.src_a - ex_io.src_b;
      OP_SLT:  sc_res = {{(DATA_W-1){1'b0}}, ($signed(ex_io.src_a) < $signed(ex_io.src_b))};
      OP_SLTU: sc_res = {{(DATA_W-1){1'b0}}, (ex_io.src_a < ex_io.src_b)};
      OP_XOR:  sc_res = ex_io.src_a ^ ex_io.src_b;
      OP_NOR:  sc_res = ~(ex_io.src_a | ex_io.src_b);
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
`ifdef ALU_EXEC_SHIFT_EN
      OP_SLL:  sc_res = ex_io.src_b << sh_amt;
      OP_SRL:  sc_res = ex_io.src_b >> sh_amt;
      OP_SRA:  sc_res = DATA_W'($signed(ex_io.src_b) >>> sh_amt);
`endif
      default: sc_res = ex_io.src_a & ex_io.src_b;
    endcase
  end

  logic                accept, is_long, sgn, a_neg, b_neg, div_ok;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum, div_sh, div_diff;
  logic [PROD_W-1:0]   fix_prod;

  assign accept   = ex_io.in_valid & ready_q;
  assign is_long  = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign sgn      = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg    = sgn & ex_io.src_a[DATA_W-1];
  assign b_neg    = sgn & ex_io.src_b[DATA_W-1];
  assign a_mag    = a_neg ? -ex_io.src_a : ex_io.src_a;
  assign b_mag    = b_neg ? -ex_io.src_b : ex_io.src_b;
  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[PROD_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q[PROD_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_ok   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign fix_prod = negq_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    rv_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_long) begin
          is_div_d = (op == OP_DIV) || (op == OP_DIVU);
          negq_d   = a_neg ^ b_neg;
          negr_d   = a_neg;
          dz_d     = (ex_io.src_b == '0);
          opnd_d   = is_div_d ? b_mag : a_mag;
          acc_d    = {{DATA_W{1'b0}}, (is_div_d ? a_mag : b_mag)};
          cnt_d    = '0;
          state_d  = is_div_d ? S_DIV : S_MUL;
        end else if (accept) begin
          result_d = sc_res;
          zero_d   = (sc_res == '0);
          rv_d     = 1'b1;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {(div_ok ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0]),
                 acc_q[DATA_W-2:0], div_ok};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = negr_q ? -acc_q[PROD_W-1:DATA_W] : acc_q[PROD_W-1:DATA_W];
          lo_d = dz_q ? '1 : (negq_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
        end else begin
          hi_d = fix_prod[PROD_W-1:DATA_W];
          lo_d = fix_prod[DATA_W-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      rv_q     <= 1'b0;
      ready_q  <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      ready_q  <= ready_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
    end
  end

  assign ex_io.in_ready     = ready_q;
  assign ex_io.result       = result_q;
  assign ex_io.result_valid = rv_q;
  assign ex_io.zero         = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, mult/div latency and HI/LO, reset abort.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit_if #(.DATA_W(32), .FUNCT_W(6)) bus ();

  alu_exec_unit #(.DATA_W(32), .FUNCT_W(6), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .ex_io (bus)
  );

  always #5 clk = ~clk;

  // Drive one op for a single accept edge; returns #1 after that edge.
  task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op   = op;
    bus.funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", bus.result_valid); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", bus.zero); end
  endtask

  task automatic test_add_sub;
    do_op(2'b00, 6'h0, 32'd5, 32'd7);
    checks++; if (bus.result !== 32'd12 || bus.zero !== 1'b0 || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL add got %h z%b v%b want 0000000c z0 v1", bus.result, bus.zero, bus.result_valid); end
    @(posedge clk); #1;
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rv_idle got %b want 0", bus.result_valid); end
    do_op(2'b01, 6'h0, 32'd5, 32'd5);
    checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL sub_zero got %h z%b want 0 z1", bus.result, bus.zero); end
    do_op(2'b01, 6'h0, 32'd3, 32'd5);
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_wrap got %h want fffffffe", bus.result); end
    do_op(2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1);
    checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL add_wrap got %h z%b want 0 z1", bus.result, bus.zero); end
    do_op(2'b10, 6'b100010, 32'd10, 32'd4);
    checks++; if (bus.result !== 32'd6) begin errors++; $display("FAIL rsub got %h want 6", bus.result); end
  endtask

  task automatic test_compare;
    do_op(2'b10, 6'b101010, 32'hFFFFFFFB, 32'd3);
    checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL slt got %h want 1", bus.result); end
    do_op(2'b10, 6'b101011, 32'hFFFFFFFB, 32'd3);
    checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin errors++; $display("FAIL sltu got %h want 0", bus.result); end
    do_op(2'b10, 6'b101011, 32'd3, 32'hFFFFFFFB);
    checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL sltu_rev got %h want 1", bus.result); end
  endtask

  task automatic test_logic;
    do_op(2'b10, 6'b100100, 32'hF0F0, 32'hFF00);
    checks++; if (bus.result !== 32'hF000) begin errors++; $display("FAIL and got %h want f000", bus.result); end
    do_op(2'b10, 6'b100101, 32'hF0F0, 32'hFF00);
    checks++; if (bus.result !== 32'hFFF0) begin errors++; $display("FAIL or got %h want fff0", bus.result); end
    do_op(2'b10, 6'b100110, 32'hF0F0, 32'hFF00);
    checks++; if (bus.result !== 32'h0FF0) begin errors++; $display("FAIL xor got %h want 0ff0", bus.result); end
    do_op(2'b10, 6'b100111, 32'hF0F0, 32'hFF00);
    checks++; if (bus.result !== 32'hFFFF000F) begin errors++; $display("FAIL nor got %h want ffff000f", bus.result); end
    do_op(2'b11, 6'b000000, 32'h1200, 32'h0034);
    checks++; if (bus.result !== 32'h1234) begin errors++; $display("FAIL ori got %h want 1234", bus.result); end
    do_op(2'b10, 6'b111111, 32'hF0F0, 32'hFF00);
    checks++; if (bus.result !== 32'hF000) begin errors++; $display("FAIL default_and got %h want f000", bus.result); end
  endtask

  task automatic test_back_to_back;
    bus.alu_op = 2'b00; bus.src_a = 32'd1; bus.src_b = 32'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.result !== 32'd3 || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h v%b want 3 v1", bus.result, bus.result_valid); end
    bus.alu_op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'd4;
    @(posedge clk); #1;
    checks++; if (bus.result !== 32'd5 || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h v%b want 5 v1", bus.result, bus.result_valid); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.result_valid !== 1'b0 || bus.result !== 32'd5) begin
      errors++; $display("FAIL b2b_drop got %h v%b want 5 v0", bus.result, bus.result_valid); end
  endtask

  task automatic test_mult;
    int n;
    do_op(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7);
    bus.src_a = 32'h12345678; bus.src_b = 32'h9ABCDEF0;
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL mult_rv got %b want 0", bus.result_valid); end
    wait_idle(n);
    checks++; if (n != 33) begin errors++; $display("FAIL mult_latency got %0d want 33", n); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFF || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL mult_hi got %h v%b want ffffffff v1", bus.result, bus.result_valid); end
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", bus.result); end
    do_op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL multu_hi got %h want 1", bus.result); end
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", bus.result); end
  endtask

  task automatic test_div;
    int n;
    do_op(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 33) begin errors++; $display("FAIL div_latency got %0d want 33", n); end
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.result); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.result); end
    do_op(2'b10, 6'b011011, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n != 33) begin errors++; $display("FAIL div0_latency got %0d want 33", n); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'd7) begin errors++; $display("FAIL div0_hi got %h want 7", bus.result); end
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", bus.result); end
    do_op(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", bus.result); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin errors++; $display("FAIL divmin_hi got %h want 0", bus.result); end
    do_op(2'b10, 6'b011010, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'hFFFFFFFD) begin errors++; $display("FAIL divneg_lo got %h want fffffffd", bus.result); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL divneg_hi got %h want 1", bus.result); end
  endtask

  task automatic test_ignore_busy;
    int n;
    do_op(2'b10, 6'b011011, 32'd100, 32'd7);
    bus.alu_op = 2'b00; bus.src_a = 32'd1; bus.src_b = 32'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ignore got v%b r%b want v0 r0", bus.result_valid, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    wait_idle(n);
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL busy_lo got %h want e", bus.result); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'd2) begin errors++; $display("FAIL busy_hi got %h want 2", bus.result); end
  endtask

  task automatic test_shift;
`ifdef ALU_EXEC_SHIFT_EN
    bus.shamt = 5'd4;
    do_op(2'b10, 6'b000011, 32'h0, 32'h80000000);
    checks++; if (bus.result !== 32'hF8000000) begin errors++; $display("FAIL sra got %h want f8000000", bus.result); end
    do_op(2'b10, 6'b000010, 32'h0, 32'h80000000);
    checks++; if (bus.result !== 32'h08000000) begin errors++; $display("FAIL srl got %h want 08000000", bus.result); end
    do_op(2'b10, 6'b000100, 32'd4, 32'd1);
    checks++; if (bus.result !== 32'h10) begin errors++; $display("FAIL sllv got %h want 10", bus.result); end
    bus.shamt = 5'd0;
`else
    do_op(2'b10, 6'b000011, 32'hF0F0F0F0, 32'h80000000);
    checks++; if (bus.result !== 32'h80000000) begin errors++; $display("FAIL sra_as_and got %h want 80000000", bus.result); end
    do_op(2'b10, 6'b000000, 32'h0000FFFF, 32'h00FF00FF);
    checks++; if (bus.result !== 32'h000000FF) begin errors++; $display("FAIL sll_as_and got %h want ff", bus.result); end
`endif
  endtask

  task automatic test_reset_abort;
    do_op(2'b10, 6'b011000, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bus.in_ready); end
    do_op(2'b10, 6'b010000, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'h0 || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL abort_hi got %h v%b want 0 v1", bus.result, bus.result_valid); end
    do_op(2'b10, 6'b010010, 32'h0, 32'h0);
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_lo got %h want 0", bus.result); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.alu_op   = 2'b00;
    bus.funct    = 6'h0;
    bus.src_a    = 32'h0;
    bus.src_b    = 32'h0;
`ifdef ALU_EXEC_SHIFT_EN
    bus.shamt    = 5'd0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_add_sub;
    test_compare;
    test_logic;
    test_back_to_back;
    test_mult;
    test_div;
    test_ignore_busy;
    test_shift;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
